// File: rtl/lane_arbiter_mux.sv
// Four-lane round-robin merge with a burst-limited priority pointer and one registered output stage.
// Each word is tagged with its source lane so a downstream demux can route replies back.
module lane_arbiter_mux #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] c_data,
  input  logic             c_valid,
  output logic             c_ready,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_n;

  logic [3:0]       vld;
  logic [3:0]       rdy;
  logic [WIDTH-1:0] lane_dat [4];
  logic             load, any_vld, take;
  logic [1:0]       gnt, idx;

  assign vld         = {d_valid, c_valid, b_valid, a_valid};
  assign lane_dat[0] = a_data;
  assign lane_dat[1] = b_data;
  assign lane_dat[2] = c_data;
  assign lane_dat[3] = d_data;
  assign load        = !out_valid_q || out_ready;
  assign take        = !reset && load && any_vld;

  // Scan farthest-to-nearest so the valid lane closest to ptr overrides the rest.
  always_comb begin
    gnt     = ptr_q;
    any_vld = 1'b0;
    idx     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (vld[idx]) begin
        gnt     = idx;
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    rdy = 4'b0000;
    if (take) rdy[gnt] = 1'b1;
  end

  assign a_ready = rdy[0];
  assign b_ready = rdy[1];
  assign c_ready = rdy[2];
  assign d_ready = rdy[3];

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cnt_n       = (gnt == last_q) ? cnt_q + CW'(1) : CW'(1);
    if (load) begin
      out_valid_d = any_vld;
      if (any_vld) begin
        out_data_d = lane_dat[gnt];
        out_sel_d  = gnt;
        last_d     = gnt;
        // Burst exhausted: hand priority to the next lane even if this one stays busy.
        if (cnt_n == BURST_MAX) begin
          ptr_d = gnt + 2'd1;
          cnt_d = '0;
        end else begin
          ptr_d = gnt;
          cnt_d = cnt_n;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      last_q      <= 2'd0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_lane_arbiter_mux.sv
// Bench for lane_arbiter_mux: a pure round-robin instance and a burst-2 instance, each
// compared every cycle against a queue-free behavioural model, plus literal directed sequences.
module tb_lane_arbiter_mux;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] sdat [2][4];
  logic [3:0]   svld [2];
  logic         ordy [2];
  logic [W-1:0] odat [2];
  logic [1:0]   osel [2];
  logic         ovld [2];
  logic [3:0]   rdy  [2];

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    chk_en  = 1'b0;
  int    mb [2]  = '{1, 2};
  string nm [2]  = '{"mb1", "mb2"};

  int           m_ptr [2];
  int           m_cnt [2];
  int           m_last[2];
  int           m_sel [2];
  logic         m_vld [2];
  logic [W-1:0] m_dat [2];

  lane_arbiter_mux #(.WIDTH(W), .MAX_BURST(1)) u_rr (
    .clk(clk), .reset(rst),
    .a_data(sdat[0][0]), .a_valid(svld[0][0]), .a_ready(rdy[0][0]),
    .b_data(sdat[0][1]), .b_valid(svld[0][1]), .b_ready(rdy[0][1]),
    .c_data(sdat[0][2]), .c_valid(svld[0][2]), .c_ready(rdy[0][2]),
    .d_data(sdat[0][3]), .d_valid(svld[0][3]), .d_ready(rdy[0][3]),
    .out_data(odat[0]), .out_sel(osel[0]), .out_valid(ovld[0]), .out_ready(ordy[0])
  );

  lane_arbiter_mux #(.WIDTH(W), .MAX_BURST(2)) u_b2 (
    .clk(clk), .reset(rst),
    .a_data(sdat[1][0]), .a_valid(svld[1][0]), .a_ready(rdy[1][0]),
    .b_data(sdat[1][1]), .b_valid(svld[1][1]), .b_ready(rdy[1][1]),
    .c_data(sdat[1][2]), .c_valid(svld[1][2]), .c_ready(rdy[1][2]),
    .d_data(sdat[1][3]), .d_valid(svld[1][3]), .d_ready(rdy[1][3]),
    .out_data(odat[1]), .out_sel(osel[1]), .out_valid(ovld[1]), .out_ready(ordy[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Lane that wins this cycle, or -1 when no lane may transfer.
  function automatic int mgrant(input int k);
    if (rst) return -1;
    if (m_vld[k] && !ordy[k]) return -1;
    for (int i = 0; i < 4; i++)
      if (svld[k][(m_ptr[k] + i) % 4]) return (m_ptr[k] + i) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int g;
      int cn;
      g = mgrant(k);
      if (rst) begin
        m_vld[k] = 1'b0; m_dat[k] = '0; m_sel[k] = 0;
        m_ptr[k] = 0;    m_cnt[k] = 0;  m_last[k] = 0;
      end else if (m_vld[k] && !ordy[k]) begin
        m_vld[k] = 1'b1;
      end else if (g < 0) begin
        m_vld[k] = 1'b0;
      end else begin
        m_vld[k] = 1'b1;
        m_dat[k] = sdat[k][g];
        m_sel[k] = g;
        cn = (g == m_last[k]) ? m_cnt[k] + 1 : 1;
        m_last[k] = g;
        if (cn == mb[k]) begin
          m_ptr[k] = (g + 1) % 4;
          m_cnt[k] = 0;
        end else begin
          m_ptr[k] = g;
          m_cnt[k] = cn;
        end
      end
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int g;
        g = mgrant(k);
        chk($sformatf("%s.out_valid", nm[k]), int'(ovld[k]), int'(m_vld[k]));
        chk($sformatf("%s.out_data", nm[k]), int'(odat[k]), int'(m_dat[k]));
        chk($sformatf("%s.out_sel", nm[k]), int'(osel[k]), m_sel[k]);
        for (int l = 0; l < 4; l++)
          chk($sformatf("%s.ready%0d", nm[k], l), int'(rdy[k][l]), (g == l) ? 1 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic [3:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    for (int k = 0; k < 2; k++) begin
      svld[k]    = v;
      sdat[k][0] = d0;
      sdat[k][1] = d1;
      sdat[k][2] = d2;
      sdat[k][3] = d3;
    end
  endtask

  int e2s [6] = '{0, 1, 2, 3, 0, 1};
  int e2d [6] = '{1, 2, 3, 4, 1, 2};
  int e3s [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    logic [3:0] fired [2];
    rst     = 1'b1;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    lanes(4'($urandom), 4'd1, 4'd2, 4'd3, 4'd4);

    // Reset with arbitrary valids, then a lone lane A.
    for (int c = 0; c < 2; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        chk("t1.readys", int'(rdy[k]), 0);
        chk("t1.out_valid", int'(ovld[k]), 0);
        chk("t1.out_data", int'(odat[k]), 0);
        chk("t1.out_sel", int'(osel[k]), 0);
      end
      lanes(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    rst = 1'b0;
    lanes(4'b0001, 4'd7, 4'd0, 4'd0, 4'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      chk("t1.first_sel", int'(osel[k]), 0);
      chk("t1.first_valid", int'(ovld[k]), 1);
      chk("t1.first_data", int'(odat[k]), 7);
    end

    // All lanes busy: pure round robin vs burst of two.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lanes(4'hF, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t3.sel[%0d]", i), int'(osel[1]), e3s[i]);
      if (i < 6) begin
        chk($sformatf("t2.sel[%0d]", i), int'(osel[0]), e2s[i]);
        chk($sformatf("t2.data[%0d]", i), int'(odat[0]), e2d[i]);
      end
    end

    // Output stall while holding lane B's word.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lanes(4'hF, 4'd1, 4'd2, 4'd3, 4'd4);
    step();
    step();
    ordy[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("t4.readys", int'(rdy[0]), 0);
      chk("t4.hold_valid", int'(ovld[0]), 1);
      chk("t4.hold_sel", int'(osel[0]), 1);
      chk("t4.hold_data", int'(odat[0]), 2);
      if (j < 3) step();
    end
    ordy[0] = 1'b1;
    step();
    chk("t4.resume_sel", int'(osel[0]), 2);
    chk("t4.resume_data", int'(odat[0]), 3);

    // Lone lane C keeps the grant through every pointer rotation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lanes(4'b0100, 4'd0, 4'd0, 4'd5, 4'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
      for (int k = 0; k < 2; k++) chk("t5.c_ready", int'(rdy[k][2]), 1);
      step();
      for (int k = 0; k < 2; k++) begin
        chk("t5.sel", int'(osel[k]), 2);
        chk("t5.data", int'(odat[k]), 5);
        chk("t5.valid", int'(ovld[k]), 1);
      end
    end
    lanes(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    for (int k = 0; k < 2; k++) chk("t5.drain_valid", int'(ovld[k]), 0);

    // Reset mid-burst restores lane A priority.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lanes(4'hF, 4'd1, 4'd2, 4'd3, 4'd4);
    repeat (5) step();
    chk("t6.pre_sel", int'(osel[1]), 2);
    rst = 1'b1;
    step();
    chk("t6.rst_valid", int'(ovld[1]), 0);
    rst = 1'b0;
    step();
    chk("t6.after_sel", int'(osel[1]), 0);
    chk("t6.after_valid", int'(ovld[1]), 1);

    // Random traffic; each source holds valid/data until its handshake.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) fired[k] = svld[k] & rdy[k];
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++) begin
        ordy[k] = ($urandom_range(0, 3) != 0);
        for (int l = 0; l < 4; l++) begin
          if (fired[k][l] || !svld[k][l]) begin
            svld[k][l] = ($urandom_range(0, 2) != 0);
            sdat[k][l] = W'($urandom);
          end
        end
      end
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
